// File: rtl/ex_stage_if.sv
// Decode -> EX -> memory stage handshake and data-SRAM request bundle.
// The EX stage connects through the slave modport; its environment uses master.
interface ex_stage_if;
    logic        ds_to_es_valid;
    logic        es_allowin;
    logic [31:0] ds_pc;
    logic [18:0] ds_alu_op;
    logic [31:0] ds_alu_src1;
    logic [31:0] ds_alu_src2;
    logic [31:0] ds_rkd_value;
    logic        ds_res_from_mem;
    logic        ds_mem_we;
    logic        ds_rf_we;
    logic [4:0]  ds_rf_waddr;
    logic [7:0]  ds_mem_inst;

    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [31:0] es_pc;
    logic [31:0] es_alu_result;
    logic        es_rf_we;
    logic [4:0]  es_rf_waddr;
    logic        es_res_from_mem;
    logic [7:0]  es_mem_inst;

    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;

    modport master (
        output ds_to_es_valid, ds_pc, ds_alu_op, ds_alu_src1, ds_alu_src2,
               ds_rkd_value, ds_res_from_mem, ds_mem_we, ds_rf_we, ds_rf_waddr,
               ds_mem_inst, ms_allowin,
        input  es_allowin, es_to_ms_valid, es_pc, es_alu_result, es_rf_we,
               es_rf_waddr, es_res_from_mem, es_mem_inst,
               data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
    );

    modport slave (
        input  ds_to_es_valid, ds_pc, ds_alu_op, ds_alu_src1, ds_alu_src2,
               ds_rkd_value, ds_res_from_mem, ds_mem_we, ds_rf_we, ds_rf_waddr,
               ds_mem_inst, ms_allowin,
        output es_allowin, es_to_ms_valid, es_pc, es_alu_result, es_rf_we,
               es_rf_waddr, es_res_from_mem, es_mem_inst,
               data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
    );
endinterface

// File: rtl/ex_stage.sv
// LoongArch execute stage: ALU, single-cycle multiplier, 32-step restoring
// divider, and data-SRAM request generation for loads and stores.
module ex_stage (
    input  logic       clk,
    input  logic       resetn,
    ex_stage_if.slave  bus
);
    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_BUSY = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

    logic        es_valid_q, es_valid_d;
    logic [31:0] pc_q, pc_d;
    logic [18:0] alu_op_q, alu_op_d;
    logic [31:0] src1_q, src1_d;
    logic [31:0] src2_q, src2_d;
    logic [31:0] rkd_q, rkd_d;
    logic        res_from_mem_q, res_from_mem_d;
    logic        mem_we_q, mem_we_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [7:0]  mem_inst_q, mem_inst_d;

    logic [1:0]  div_state_q, div_state_d;
    logic [5:0]  div_cnt_q, div_cnt_d;
    logic [31:0] div_rem_q, div_rem_d;
    logic [31:0] div_quo_q, div_quo_d;
    logic [31:0] div_b_q, div_b_d;
    logic        div_sign_a_q, div_sign_a_d;
    logic        div_sign_b_q, div_sign_b_d;

    logic        es_ready_go;
    logic        es_allowin;
    logic        es_to_ms_valid;
    logic        load;
    logic        is_div_op;
    logic        div_signed;

    assign is_div_op      = |alu_op_q[18:15];
    assign div_signed     = alu_op_q[15] | alu_op_q[17];
    assign es_ready_go    = is_div_op ? (div_state_q == DIV_DONE) : 1'b1;
    assign es_allowin     = !es_valid_q | (es_ready_go & bus.ms_allowin);
    assign es_to_ms_valid = es_valid_q & es_ready_go;
    assign load           = es_allowin & bus.ds_to_es_valid;

    always_comb begin
        es_valid_d     = es_allowin ? bus.ds_to_es_valid : es_valid_q;
        pc_d           = load ? bus.ds_pc           : pc_q;
        alu_op_d       = load ? bus.ds_alu_op       : alu_op_q;
        src1_d         = load ? bus.ds_alu_src1     : src1_q;
        src2_d         = load ? bus.ds_alu_src2     : src2_q;
        rkd_d          = load ? bus.ds_rkd_value    : rkd_q;
        res_from_mem_d = load ? bus.ds_res_from_mem : res_from_mem_q;
        mem_we_d       = load ? bus.ds_mem_we       : mem_we_q;
        rf_we_d        = load ? bus.ds_rf_we        : rf_we_q;
        rf_waddr_d     = load ? bus.ds_rf_waddr     : rf_waddr_q;
        mem_inst_d     = load ? bus.ds_mem_inst     : mem_inst_q;
    end

    // ALU and multiplier datapath, all combinational from latched operands
    logic signed [31:0] src1_s, src2_s;
    logic [31:0]        add_res, sub_res, slt_res, sltu_res;
    logic [31:0]        sll_res, srl_res, sra_res;
    logic signed [32:0] mul_a, mul_b;
    logic signed [63:0] mul_prod;

    assign src1_s   = src1_q;
    assign src2_s   = src2_q;
    assign add_res  = src1_q + src2_q;
    assign sub_res  = src1_q - src2_q;
    assign slt_res  = {31'd0, src1_s < src2_s};
    assign sltu_res = {31'd0, src1_q < src2_q};
    assign sll_res  = src1_q << src2_q[4:0];
    assign srl_res  = src1_q >> src2_q[4:0];
    assign sra_res  = src1_s >>> src2_q[4:0];

    // Only mulh.w sign-extends; mul.w low bits are identical either way
    assign mul_a    = {alu_op_q[13] & src1_q[31], src1_q};
    assign mul_b    = {alu_op_q[13] & src2_q[31], src2_q};
    assign mul_prod = 64'(mul_a) * 64'(mul_b);

    // Restoring divider step: magnitude dividend shifts out of div_quo_q
    logic [32:0] div_partial;
    logic        div_geq;
    logic [31:0] div_rem_sub;
    logic [31:0] div_quo_fix, div_rem_fix, div_res;

    assign div_partial = {div_rem_q, div_quo_q[31]};
    assign div_geq     = div_partial >= {1'b0, div_b_q};
    assign div_rem_sub = div_partial[31:0] - div_b_q;
    assign div_quo_fix = neg_if(div_sign_a_q ^ div_sign_b_q, div_quo_q);
    assign div_rem_fix = neg_if(div_sign_a_q, div_rem_q);
    assign div_res     = (alu_op_q[15] | alu_op_q[16]) ? div_quo_fix : div_rem_fix;

    always_comb begin
        div_state_d  = div_state_q;
        div_cnt_d    = div_cnt_q;
        div_rem_d    = div_rem_q;
        div_quo_d    = div_quo_q;
        div_b_d      = div_b_q;
        div_sign_a_d = div_sign_a_q;
        div_sign_b_d = div_sign_b_q;
        case (div_state_q)
            DIV_IDLE: begin
                if (es_valid_q && is_div_op) begin
                    div_sign_a_d = div_signed & src1_q[31];
                    div_sign_b_d = div_signed & src2_q[31];
                    div_quo_d    = neg_if(div_signed & src1_q[31], src1_q);
                    div_b_d      = neg_if(div_signed & src2_q[31], src2_q);
                    div_rem_d    = 32'd0;
                    div_cnt_d    = 6'd0;
                    div_state_d  = DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                div_rem_d = div_geq ? div_rem_sub : div_partial[31:0];
                div_quo_d = {div_quo_q[30:0], div_geq};
                div_cnt_d = div_cnt_q + 6'd1;
                if (div_cnt_q == 6'd31) begin
                    div_state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (es_to_ms_valid && bus.ms_allowin) begin
                    div_state_d = DIV_IDLE;
                end
            end
            default: div_state_d = DIV_IDLE;
        endcase
    end

    logic [31:0] alu_result;

    assign alu_result = ({32{alu_op_q[0]}}  & add_res)
                      | ({32{alu_op_q[1]}}  & sub_res)
                      | ({32{alu_op_q[2]}}  & slt_res)
                      | ({32{alu_op_q[3]}}  & sltu_res)
                      | ({32{alu_op_q[4]}}  & (src1_q & src2_q))
                      | ({32{alu_op_q[5]}}  & ~(src1_q | src2_q))
                      | ({32{alu_op_q[6]}}  & (src1_q | src2_q))
                      | ({32{alu_op_q[7]}}  & (src1_q ^ src2_q))
                      | ({32{alu_op_q[8]}}  & sll_res)
                      | ({32{alu_op_q[9]}}  & srl_res)
                      | ({32{alu_op_q[10]}} & sra_res)
                      | ({32{alu_op_q[11]}} & src2_q)
                      | ({32{alu_op_q[12]}} & mul_prod[31:0])
                      | ({32{alu_op_q[13] | alu_op_q[14]}} & mul_prod[63:32])
                      | ({32{is_div_op}}    & div_res);

    // Store strobes and lane-replicated write data
    logic       st_b, st_h, st_w;
    logic [3:0] we_raw;

    assign st_b = mem_inst_q[7];
    assign st_h = mem_inst_q[6];
    assign st_w = mem_inst_q[5];

    always_comb begin
        we_raw = 4'b0000;
        if (st_w) begin
            we_raw = 4'b1111;
        end else if (st_h) begin
            we_raw = alu_result[1] ? 4'b1100 : 4'b0011;
        end else if (st_b) begin
            we_raw = 4'b0001 << alu_result[1:0];
        end
    end

    assign bus.es_allowin      = es_allowin;
    assign bus.es_to_ms_valid  = es_to_ms_valid;
    assign bus.es_pc           = pc_q;
    assign bus.es_alu_result   = alu_result;
    assign bus.es_rf_we        = rf_we_q & es_valid_q;
    assign bus.es_rf_waddr     = rf_waddr_q;
    assign bus.es_res_from_mem = res_from_mem_q & es_valid_q;
    assign bus.es_mem_inst     = mem_inst_q;
    assign bus.data_sram_en    = es_valid_q & (res_from_mem_q | mem_we_q);
    assign bus.data_sram_we    = (es_valid_q & mem_we_q) ? we_raw : 4'b0000;
    assign bus.data_sram_addr  = alu_result;
    assign bus.data_sram_wdata = st_b ? {4{rkd_q[7:0]}}
                               : st_h ? {2{rkd_q[15:0]}}
                               : rkd_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            es_valid_q     <= 1'b0;
            pc_q           <= '0;
            alu_op_q       <= '0;
            src1_q         <= '0;
            src2_q         <= '0;
            rkd_q          <= '0;
            res_from_mem_q <= 1'b0;
            mem_we_q       <= 1'b0;
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= '0;
            mem_inst_q     <= '0;
            div_state_q    <= DIV_IDLE;
            div_cnt_q      <= '0;
            div_rem_q      <= '0;
            div_quo_q      <= '0;
            div_b_q        <= '0;
            div_sign_a_q   <= 1'b0;
            div_sign_b_q   <= 1'b0;
        end else begin
            es_valid_q     <= es_valid_d;
            pc_q           <= pc_d;
            alu_op_q       <= alu_op_d;
            src1_q         <= src1_d;
            src2_q         <= src2_d;
            rkd_q          <= rkd_d;
            res_from_mem_q <= res_from_mem_d;
            mem_we_q       <= mem_we_d;
            rf_we_q        <= rf_we_d;
            rf_waddr_q     <= rf_waddr_d;
            mem_inst_q     <= mem_inst_d;
            div_state_q    <= div_state_d;
            div_cnt_q      <= div_cnt_d;
            div_rem_q      <= div_rem_d;
            div_quo_q      <= div_quo_d;
            div_b_q        <= div_b_d;
            div_sign_a_q   <= div_sign_a_d;
            div_sign_b_q   <= div_sign_b_d;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed cases with literal expectations plus a random
// instruction stream checked every cycle against a behavioural model.
module tb_ex_stage;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    ex_stage_if bus_if();

    ex_stage dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;
    logic [31:0] next_pc = 32'h1c00_0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Architectural result of one op; bit 32 is 0 when the value is unspecified
    function automatic logic [32:0] model_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        longint      p;
        logic [63:0] pu;
        logic [31:0] r;
        logic        known;
        sa = a;
        sb = b;
        known = 1'b1;
        r = 32'd0;
        case (op)
            0:  r = a + b;
            1:  r = a - b;
            2:  r = (sa < sb) ? 32'd1 : 32'd0;
            3:  r = (a < b) ? 32'd1 : 32'd0;
            4:  r = a & b;
            5:  r = ~(a | b);
            6:  r = a | b;
            7:  r = a ^ b;
            8:  r = a << b[4:0];
            9:  r = a >> b[4:0];
            10: r = sa >>> b[4:0];
            11: r = b;
            12: begin p = longint'(sa) * longint'(sb); r = p[31:0]; end
            13: begin p = longint'(sa) * longint'(sb); r = p[63:32]; end
            14: begin pu = {32'd0, a} * {32'd0, b}; r = pu[63:32]; end
            15: if (b == 0) known = 1'b0;
                else begin p = longint'(sa) / longint'(sb); r = p[31:0]; end
            16: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            17: if (b == 0) known = 1'b0;
                else begin p = longint'(sa) % longint'(sb); r = p[31:0]; end
            18: r = (b == 0) ? a : a % b;
            default: r = 32'd0;
        endcase
        return {known, r};
    endfunction

    function automatic int op_index(input logic [18:0] v);
        for (int i = 0; i < 19; i++) if (v[i]) return i;
        return 19;
    endfunction

    // Model of what EX currently holds
    logic        m_valid = 1'b0;
    int          m_op    = 19;
    int          m_age   = 0;
    logic [31:0] m_a = '0, m_b = '0, m_rkd = '0, m_pc = '0;
    logic [7:0]  m_mi = '0;
    logic        m_we = 1'b0, m_rfm = 1'b0, m_rfwe = 1'b0;
    logic [4:0]  m_wa = '0;

    always @(negedge clk) begin : cmp_proc
        logic [32:0] mr;
        logic        is_div, ready, allow;
        logic [3:0]  we_exp;
        logic [31:0] wd_exp;
        is_div = (m_op >= 15) && (m_op <= 18);
        ready  = !is_div || (m_age >= 33);
        allow  = !m_valid || (ready && bus_if.ms_allowin);
        if (cmp_en) begin
            mr = model_alu(m_op, m_a, m_b);
            chk("es_allowin", bus_if.es_allowin, allow);
            chk("es_to_ms_valid", bus_if.es_to_ms_valid, m_valid & ready);
            chk("es_rf_we", bus_if.es_rf_we, m_valid & m_rfwe);
            chk("es_res_from_mem", bus_if.es_res_from_mem, m_valid & m_rfm);
            chk("es_rf_waddr", bus_if.es_rf_waddr, m_wa);
            chk("es_pc", bus_if.es_pc, m_pc);
            chk("es_mem_inst", bus_if.es_mem_inst, m_mi);
            chk("data_sram_en", bus_if.data_sram_en, m_valid & (m_rfm | m_we));
            wd_exp = m_mi[7] ? {4{m_rkd[7:0]}} : m_mi[6] ? {2{m_rkd[15:0]}} : m_rkd;
            chk("data_sram_wdata", bus_if.data_sram_wdata, wd_exp);
            if (!m_valid || !m_we) begin
                chk("data_sram_we_idle", bus_if.data_sram_we, 4'b0000);
            end
            if (m_valid && ready && mr[32]) begin
                chk("es_alu_result", bus_if.es_alu_result, mr[31:0]);
                chk("data_sram_addr", bus_if.data_sram_addr, mr[31:0]);
                if (m_we) begin
                    if (m_mi[5])      we_exp = 4'b1111;
                    else if (m_mi[6]) we_exp = 4'b0011 << {mr[1], 1'b0};
                    else if (m_mi[7]) we_exp = 4'b0001 << mr[1:0];
                    else              we_exp = 4'b0000;
                    chk("data_sram_we", bus_if.data_sram_we, we_exp);
                end
            end
        end
        if (!resetn) begin
            m_valid = 1'b0; m_op = 19; m_age = 0;
            m_a = '0; m_b = '0; m_rkd = '0; m_pc = '0; m_mi = '0;
            m_we = 1'b0; m_rfm = 1'b0; m_rfwe = 1'b0; m_wa = '0;
        end else if (allow) begin
            m_valid = bus_if.ds_to_es_valid;
            if (bus_if.ds_to_es_valid) begin
                m_op = op_index(bus_if.ds_alu_op);
                m_a = bus_if.ds_alu_src1; m_b = bus_if.ds_alu_src2;
                m_rkd = bus_if.ds_rkd_value; m_pc = bus_if.ds_pc;
                m_mi = bus_if.ds_mem_inst; m_we = bus_if.ds_mem_we;
                m_rfm = bus_if.ds_res_from_mem; m_rfwe = bus_if.ds_rf_we;
                m_wa = bus_if.ds_rf_waddr; m_age = 0;
            end
        end else begin
            m_age++;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge
    task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] rkd, input logic [7:0] mi, input logic we,
                         input logic rfm, input logic rfwe, input logic [4:0] wa,
                         input bit rnd_bp);
        logic acc;
        bit   accepted;
        bus_if.ds_to_es_valid  = 1'b1;
        bus_if.ds_pc           = next_pc;
        bus_if.ds_alu_op       = (op < 19) ? (19'd1 << op) : 19'd0;
        bus_if.ds_alu_src1     = a;
        bus_if.ds_alu_src2     = b;
        bus_if.ds_rkd_value    = rkd;
        bus_if.ds_mem_inst     = mi;
        bus_if.ds_mem_we       = we;
        bus_if.ds_res_from_mem = rfm;
        bus_if.ds_rf_we        = rfwe;
        bus_if.ds_rf_waddr     = wa;
        next_pc += 32'd4;
        accepted = 1'b0;
        for (int i = 0; i < 400 && !accepted; i++) begin
            @(negedge clk);
            acc = bus_if.es_allowin;
            @(posedge clk);
            #1;
            if (acc === 1'b1) accepted = 1'b1;
            else if (rnd_bp) bus_if.ms_allowin = ($urandom_range(0, 3) != 0);
        end
        bus_if.ds_to_es_valid = 1'b0;
        chk("issue_accepted", {31'd0, accepted}, 32'd1);
    endtask

    task automatic wait_ready(output int lat);
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus_if.es_to_ms_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin : driver
        int lat;
        int hs;
        logic [31:0] held;
        resetn = 1'b0;
        bus_if.ds_to_es_valid = 1'b0; bus_if.ds_pc = '0; bus_if.ds_alu_op = '0;
        bus_if.ds_alu_src1 = '0; bus_if.ds_alu_src2 = '0; bus_if.ds_rkd_value = '0;
        bus_if.ds_res_from_mem = 1'b0; bus_if.ds_mem_we = 1'b0; bus_if.ds_rf_we = 1'b0;
        bus_if.ds_rf_waddr = '0; bus_if.ds_mem_inst = '0; bus_if.ms_allowin = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_to_ms_valid", bus_if.es_to_ms_valid, 1'b0);
        chk("rst_allowin", bus_if.es_allowin, 1'b1);
        chk("rst_sram_en", bus_if.data_sram_en, 1'b0);
        chk("rst_sram_we", bus_if.data_sram_we, 4'b0000);
        chk("rst_pc", bus_if.es_pc, 32'd0);
        chk("rst_rf_we", bus_if.es_rf_we, 1'b0);
        step();
        resetn = 1'b1;
        step();

        issue(0, 32'd7, 32'hFFFF_FFFD, 32'd0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0);
        wait_ready(lat);
        chk("add_latency", lat, 32'd0);
        chk("add_result", bus_if.es_alu_result, 32'd4);
        step();

        issue(13, 32'h8000_0000, 32'd2, 32'd0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0);
        @(negedge clk);
        chk("mulh_w", bus_if.es_alu_result, 32'hFFFF_FFFF);
        step();
        issue(14, 32'h8000_0000, 32'd2, 32'd0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0);
        @(negedge clk);
        chk("mulh_wu", bus_if.es_alu_result, 32'd1);
        step();
        issue(12, 32'h8000_0000, 32'd2, 32'd0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0);
        @(negedge clk);
        chk("mul_w", bus_if.es_alu_result, 32'd0);
        step();

        issue(15, 32'hFFFF_FFF9, 32'd2, 32'd0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
        wait_ready(lat);
        chk("div_w_latency", lat, 32'd33);
        chk("div_w_result", bus_if.es_alu_result, 32'hFFFF_FFFD);
        step();
        issue(17, 32'hFFFF_FFF9, 32'd2, 32'd0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
        wait_ready(lat);
        chk("mod_w_result", bus_if.es_alu_result, 32'hFFFF_FFFF);
        step();
        issue(16, 32'd7, 32'd0, 32'd0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
        wait_ready(lat);
        chk("div_wu_by0_latency", lat, 32'd33);
        chk("div_wu_by0", bus_if.es_alu_result, 32'hFFFF_FFFF);
        step();
        issue(18, 32'd7, 32'd0, 32'd0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
        wait_ready(lat);
        chk("mod_wu_by0", bus_if.es_alu_result, 32'd7);
        step();
        issue(15, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
        wait_ready(lat);
        chk("div_w_ovf", bus_if.es_alu_result, 32'h8000_0000);
        step();
        issue(17, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
        wait_ready(lat);
        chk("mod_w_ovf", bus_if.es_alu_result, 32'd0);
        step();
        issue(15, 32'd9, 32'd0, 32'd0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
        wait_ready(lat);
        chk("div_w_by0_latency", lat, 32'd33);
        step();

        issue(0, 32'h1000, 32'd3, 32'h0000_00AB, 8'h80, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        chk("st_b_we", bus_if.data_sram_we, 4'b1000);
        chk("st_b_wdata", bus_if.data_sram_wdata, 32'hABAB_ABAB);
        chk("st_b_en", bus_if.data_sram_en, 1'b1);
        chk("st_b_addr", bus_if.data_sram_addr, 32'h0000_1003);
        step();
        issue(0, 32'h1000, 32'd2, 32'h0000_1234, 8'h40, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        chk("st_h_we", bus_if.data_sram_we, 4'b1100);
        chk("st_h_wdata", bus_if.data_sram_wdata, 32'h1234_1234);
        step();

        bus_if.ms_allowin = 1'b0;
        issue(16, 32'd100, 32'd7, 32'd0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0);
        wait_ready(lat);
        chk("bp_latency", lat, 32'd33);
        held = bus_if.es_alu_result;
        chk("bp_result", held, 32'd14);
        hs = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_allowin_low", bus_if.es_allowin, 1'b0);
            chk("bp_result_stable", bus_if.es_alu_result, 32'd14);
            if (bus_if.es_to_ms_valid && bus_if.ms_allowin) hs++;
        end
        step();
        bus_if.ms_allowin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus_if.es_to_ms_valid && bus_if.ms_allowin) hs++;
        end
        chk("bp_handshakes", hs, 32'd1);
        step();

        issue(15, 32'd1000, 32'd3, 32'd0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0);
        repeat (10) step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        @(negedge clk);
        chk("mid_rst_to_ms_valid", bus_if.es_to_ms_valid, 1'b0);
        chk("mid_rst_allowin", bus_if.es_allowin, 1'b1);
        step();
        issue(0, 32'd5, 32'd6, 32'd0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0);
        wait_ready(lat);
        chk("post_rst_add_latency", lat, 32'd0);
        chk("post_rst_add", bus_if.es_alu_result, 32'd11);
        step();
        issue(16, 32'd9, 32'd2, 32'd0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0);
        wait_ready(lat);
        chk("post_rst_div_latency", lat, 32'd33);
        chk("post_rst_div", bus_if.es_alu_result, 32'd4);
        step();

        for (int n = 0; n < 250; n++) begin
            int          op, kind;
            logic [7:0]  mi;
            logic        we, rfm, rfwe;
            repeat ($urandom_range(0, 2)) begin
                bus_if.ms_allowin = ($urandom_range(0, 3) != 0);
                step();
            end
            op   = $urandom_range(0, 19);
            kind = (op >= 15 && op <= 18) ? 0 : $urandom_range(0, 8);
            mi   = 8'h00;
            if (kind == 1) mi = 8'h80;
            else if (kind == 2) mi = 8'h40;
            else if (kind == 3) mi = 8'h20;
            else if (kind >= 4) mi = 8'h01 << (kind - 4);
            we   = (kind >= 1 && kind <= 3);
            rfm  = (kind >= 4);
            rfwe = rfm | (!we & ($urandom_range(0, 1) == 1));
            issue(op, pick_operand(), pick_operand(), $urandom, mi, we, rfm, rfwe,
                  5'($urandom_range(0, 31)), 1'b1);
        end
        bus_if.ms_allowin = 1'b1;
        repeat (40) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
